// File: rtl/vx_credit_arbiter.sv
// -----------------------------------------------------------------------------
// vx_credit_arbiter
//
// Shares one downstream request port among NUM_REQS requesters using
// round-robin arbitration. It enforces two outstanding-request budgets: a
// global one (SIZE) and a per-requester one (PER_REQ). In-flight requests are
// tracked by counting issues against returned responses. A flush handshake
// stops new issues until every outstanding request has drained, then pulses
// flush_ack for one cycle.
//
// Handshake: a downstream issue happens ("fires") in any cycle where
// req_valid_out && req_ready_out. req_valid_out is a function of the
// requesters, the credit state and the FSM only; it never looks at
// req_ready_out. req_ready_in[i] is high only for the winner, and only in a
// cycle that fires. A response (rsp_valid_in) is always consumed in the cycle
// it is presented.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_valid_in      per-requester request valid
//   req_ready_in      per-requester accept (one-hot or zero)
//   req_valid_out     downstream request valid
//   req_idx_out       winning requester index (0 when there is no request)
//   req_ready_out     downstream accept
//   rsp_valid_in      response returned
//   rsp_idx_in        requester that owns the response
//   flush_req         drain request
//   flush_ack         one-cycle drain-complete pulse
//   pending_size      total outstanding count
//   empty, full       pending_size == 0 / pending_size == SIZE (registered)
//   dbg_state_o       flush FSM state (0 RUN, 1 DRAIN, 2 ACK)
// -----------------------------------------------------------------------------
module vx_credit_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int SIZE     = 8,
    parameter int PER_REQ  = 4,
    parameter int REQ_SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int SIZEW    = $clog2(SIZE + 1),
    parameter int CNTW     = $clog2(PER_REQ + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid_in,
    output logic [NUM_REQS-1:0] req_ready_in,
    output logic                req_valid_out,
    output logic [REQ_SELW-1:0] req_idx_out,
    input  logic                req_ready_out,
    input  logic                rsp_valid_in,
    input  logic [REQ_SELW-1:0] rsp_idx_in,
    input  logic                flush_req,
    output logic                flush_ack,
    output logic [SIZEW-1:0]    pending_size,
    output logic                empty,
    output logic                full,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [REQ_SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SIZEW-1:0]    pending_q, pending_d;
    logic                empty_q, full_q;
    logic [CNTW-1:0]     cnt_q [NUM_REQS];
    logic [CNTW-1:0]     cnt_d [NUM_REQS];

    logic [NUM_REQS-1:0] eligible;
    logic                found;
    logic [REQ_SELW-1:0] winner;
    logic [REQ_SELW-1:0] cand;
    int                  cand_int;
    logic                fire;

    // A requester may compete only while it has per-requester credit, the
    // global budget is not exhausted, and no flush is in progress.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid_in[i] && (cnt_q[i] != CNTW'(PER_REQ)) &&
                          !full_q && (state_q == ST_RUN);
        end
    end

    // Round-robin search: visit requesters in order starting at rr_ptr_q,
    // wrapping modulo NUM_REQS, and take the first eligible one.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        cand_int = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand_int = int'(rr_ptr_q) + k;
            if (cand_int >= NUM_REQS) begin
                cand_int = cand_int - NUM_REQS;
            end
            cand = REQ_SELW'(cand_int);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign fire          = found && req_ready_out;
    assign req_valid_out = found;
    assign req_idx_out   = winner;
    assign req_ready_in  = fire ? (NUM_REQS'(1) << winner) : '0;

    // The pointer moves past the winner only on an actual issue, so a stalled
    // downstream keeps offering the same requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (winner == REQ_SELW'(NUM_REQS - 1)) ? '0 : winner + REQ_SELW'(1);
        end
    end

    // An issue and a response on the same requester in one cycle cancel.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            cnt_d[i] = cnt_q[i]
                     + CNTW'(fire && (winner == REQ_SELW'(i)))
                     - CNTW'(rsp_valid_in && (rsp_idx_in == REQ_SELW'(i)));
        end
    end

    assign pending_d = pending_q + SIZEW'(fire) - SIZEW'(rsp_valid_in);

    // Flush FSM. DRAIN waits on the registered empty flag, so a flush that
    // arrives while already empty still passes through DRAIN for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: if (empty_q)   state_d = ST_ACK;
            ST_ACK:                  state_d = ST_RUN;
            default:                 state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            // Flags come from the next-state count so they line up with
            // pending_size in the same cycle.
            empty_q   <= (pending_d == '0);
            full_q    <= (pending_d == SIZEW'(SIZE));
            for (int i = 0; i < NUM_REQS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign flush_ack    = (state_q == ST_ACK);
    assign pending_size = pending_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign dbg_state_o  = state_q;

    // Credit-accounting sanity: responses must match something in flight,
    // and the eligibility gating must never let an over-budget issue through.
    always @(posedge clk) begin
        if (!reset) begin
            if (rsp_valid_in) begin
                a_rsp_not_empty: assert (!empty_q);
                a_rsp_idx_range: assert (int'(rsp_idx_in) < NUM_REQS);
                a_rsp_has_cnt:   assert (cnt_q[rsp_idx_in] != '0);
            end
            if (fire) begin
                a_fire_not_full: assert (!full_q);
                a_fire_has_cred: assert (cnt_q[winner] != CNTW'(PER_REQ));
            end
        end
    end

endmodule

// File: tb/tb_vx_credit_arbiter.sv
module tb_vx_credit_arbiter;

  localparam int NUM_REQS = 4;
  localparam int SIZE     = 8;
  localparam int PER_REQ  = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req_valid_in;
  logic [3:0] req_ready_in;
  logic       req_valid_out;
  logic [1:0] req_idx_out;
  logic       req_ready_out;
  logic       rsp_valid_in;
  logic [1:0] rsp_idx_in;
  logic       flush_req;
  logic       flush_ack;
  logic [3:0] pending_size;
  logic       empty;
  logic       full;
  logic [1:0] dbg_state_o;

  int total;
  int bad;

  vx_credit_arbiter #(
    .NUM_REQS(NUM_REQS),
    .SIZE(SIZE),
    .PER_REQ(PER_REQ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_in(req_valid_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out),
    .req_idx_out(req_idx_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in),
    .rsp_idx_in(rsp_idx_in),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .pending_size(pending_size),
    .empty(empty),
    .full(full),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Outstanding requests are kept as a list of owner indices; every count
  // the block exposes is derived from that list.
  int out_q[$];
  int m_next;        // requester the rotation starts from
  int m_phase;       // 0 normal, 1 draining, 2 acknowledging
  logic       exp_valid;
  int         exp_idx;
  logic [3:0] exp_rdy;
  logic [13:0] exp_vec;
  logic [13:0] obs_vec;

  function automatic int owned(int r);
    int n = 0;
    foreach (out_q[k]) if (out_q[k] == r) n++;
    return n;
  endfunction

  function automatic void model_reset();
    out_q.delete();
    m_next  = 0;
    m_phase = 0;
  endfunction

  function automatic void predict();
    int j;
    exp_valid = 1'b0;
    exp_idx   = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = (m_next + k) % NUM_REQS;
      if (!exp_valid && m_phase == 0 && req_valid_in[j] &&
          owned(j) < PER_REQ && out_q.size() < SIZE) begin
        exp_valid = 1'b1;
        exp_idx   = j;
      end
    end
    exp_rdy = (exp_valid && req_ready_out) ? (4'b0001 << exp_idx) : 4'b0000;
    exp_vec = {exp_valid, 2'(exp_idx), exp_rdy, (m_phase == 2), 4'(out_q.size()),
               (out_q.size() == 0), (out_q.size() == SIZE)};
    obs_vec = {req_valid_out, req_idx_out, req_ready_in, flush_ack, pending_size,
               empty, full};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic settle();
    #2;
    predict();
  endtask

  // Advance one clock edge and apply it to the model.
  task automatic tick();
    logic f;
    int   had_empty;
    f = exp_valid && req_ready_out;
    had_empty = (out_q.size() == 0);
    @(posedge clk);
    case (m_phase)
      0: if (flush_req) m_phase = 1;
      1: if (had_empty) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (rsp_valid_in) begin
      foreach (out_q[k]) begin
        if (out_q[k] == int'(rsp_idx_in)) begin
          out_q.delete(k);
          break;
        end
      end
    end
    if (f) begin
      out_q.push_back(exp_idx);
      m_next = (exp_idx + 1) % NUM_REQS;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_in  = 4'b0;
    req_ready_out = 1'b0;
    rsp_valid_in  = 1'b0;
    rsp_idx_in    = 2'd0;
    flush_req     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Return every outstanding request, one response per cycle.
  task automatic drain_all();
    int guard = 0;
    idle_inputs();
    while (out_q.size() > 0 && guard < 64) begin
      rsp_valid_in = 1'b1;
      rsp_idx_in   = 2'(out_q[0]);
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL drain_vec: got %h want %h", obs_vec, exp_vec);
      end
      tick();
      guard++;
    end
    rsp_valid_in = 1'b0;
    total++;
    if (out_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: outstanding %0d want 0", out_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    settle();
    total++;
    if ({req_valid_out, pending_size, empty, full, flush_ack} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got v=%b p=%0d e=%b f=%b a=%b want v=0 p=0 e=1 f=0 a=0",
               req_valid_out, pending_size, empty, full, flush_ack);
    end
    total++;
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_vec: got %h want %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_fill();
    int seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    idle_inputs();
    req_valid_in  = 4'b1111;
    req_ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      total++;
      if (req_valid_out !== 1'b1 || int'(req_idx_out) != seq[k]) begin
        bad++;
        $display("FAIL fill_grant%0d: got v=%b idx=%0d want v=1 idx=%0d", k, req_valid_out, req_idx_out, seq[k]);
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL fill_vec%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      tick();
    end
    settle();
    total++;
    if ({full, pending_size, req_valid_out, req_ready_in} !== {1'b1, 4'd8, 1'b0, 4'b0}) begin
      bad++;
      $display("FAIL fill_full: got f=%b p=%0d v=%b r=%b want f=1 p=8 v=0 r=0000",
               full, pending_size, req_valid_out, req_ready_in);
    end
    tick();
    drain_all();
  endtask

  task automatic test_single();
    int pseq[6] = '{1, 2, 3, 4, 3, 4};
    idle_inputs();
    req_valid_in  = 4'b0100;
    req_ready_out = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rsp_valid_in = (k == 4);
      rsp_idx_in   = 2'd2;
      settle();
      total++;
      if (req_valid_out !== (k != 4)) begin
        bad++;
        $display("FAIL single_valid%0d: got %b want %b", k, req_valid_out, (k != 4));
      end
      tick();
      total++;
      if (int'(pending_size) != pseq[k]) begin
        bad++;
        $display("FAIL single_pending%0d: got %0d want %0d", k, pending_size, pseq[k]);
      end
    end
    drain_all();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    req_valid_in  = 4'b0010;
    req_ready_out = 1'b1;
    settle(); tick();
    settle(); tick();
    rsp_valid_in = 1'b1;
    rsp_idx_in   = 2'd1;
    settle();
    total++;
    if (req_ready_in !== 4'b0010) begin
      bad++;
      $display("FAIL same_fire: got ready_in=%b want 0010", req_ready_in);
    end
    tick();
    rsp_valid_in = 1'b0;
    settle();
    total++;
    if ({pending_size, empty, full} !== {4'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL same_pending: got p=%0d e=%b f=%b want p=2 e=0 f=0", pending_size, empty, full);
    end
    // Two more issues bring requester 1 to its limit only if its count held at 2.
    tick();
    settle(); tick();
    settle();
    total++;
    if (req_valid_out !== 1'b0 || pending_size !== 4'd4) begin
      bad++;
      $display("FAIL same_cnt_limit: got v=%b p=%0d want v=0 p=4", req_valid_out, pending_size);
    end
    tick();
    drain_all();
  endtask

  task automatic test_ready_low();
    apply_reset();
    req_valid_in  = 4'b1001;
    req_ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++;
      if ({req_valid_out, req_idx_out, req_ready_in} !== {1'b1, 2'd0, 4'b0}) begin
        bad++;
        $display("FAIL stall%0d: got v=%b idx=%0d r=%b want v=1 idx=0 r=0000",
                 k, req_valid_out, req_idx_out, req_ready_in);
      end
      tick();
    end
    req_ready_out = 1'b1;
    settle();
    total++;
    if (req_ready_in !== 4'b0001) begin
      bad++;
      $display("FAIL stall_release0: got r=%b want 0001", req_ready_in);
    end
    tick();
    settle();
    total++;
    if (req_ready_in !== 4'b1000) begin
      bad++;
      $display("FAIL stall_release3: got r=%b want 1000", req_ready_in);
    end
    tick();
    drain_all();
  endtask

  task automatic test_flush();
    idle_inputs();
    req_valid_in  = 4'b0001;
    req_ready_out = 1'b1;
    for (int k = 0; k < 3; k++) begin settle(); tick(); end
    req_valid_in = 4'b0;
    flush_req    = 1'b1;
    settle(); tick();
    flush_req    = 1'b0;
    req_valid_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rsp_valid_in = (k < 3);
      rsp_idx_in   = 2'd0;
      settle();
      total++;
      if (req_valid_out !== 1'b0 || flush_ack !== 1'b0) begin
        bad++;
        $display("FAIL flush_drain%0d: got v=%b ack=%b want v=0 ack=0", k, req_valid_out, flush_ack);
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL flush_vec%0d: got %h want %h", k, obs_vec, exp_vec);
      end
      tick();
    end
    settle();
    total++;
    if ({flush_ack, req_valid_out, empty} !== {1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL flush_ack: got ack=%b v=%b e=%b want ack=1 v=0 e=1", flush_ack, req_valid_out, empty);
    end
    tick();
    settle();
    total++;
    if ({flush_ack, req_valid_out} !== {1'b0, 1'b1}) begin
      bad++;
      $display("FAIL flush_resume: got ack=%b v=%b want ack=0 v=1", flush_ack, req_valid_out);
    end
    // Flush while already empty: acknowledge two cycles after the request.
    idle_inputs();
    flush_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      total++;
      if (flush_ack !== (k == 2)) begin
        bad++;
        $display("FAIL flush_empty%0d: got ack=%b want %b", k, flush_ack, (k == 2));
      end
      tick();
      flush_req = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    req_valid_in  = 4'b1111;
    req_ready_out = 1'b1;
    for (int k = 0; k < 5; k++) begin settle(); tick(); end
    total++;
    if (pending_size !== 4'd5) begin
      bad++;
      $display("FAIL areset_pre: got p=%0d want 5", pending_size);
    end
    idle_inputs();
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({req_valid_out, pending_size, empty, full, flush_ack} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL areset_now: got v=%b p=%0d e=%b f=%b a=%b want v=0 p=0 e=1 f=0 a=0",
               req_valid_out, pending_size, empty, full, flush_ack);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid_in  = 4'b1111;
    req_ready_out = 1'b1;
    settle();
    total++;
    if (req_valid_out !== 1'b1 || req_idx_out !== 2'd0) begin
      bad++;
      $display("FAIL areset_first: got v=%b idx=%0d want v=1 idx=0", req_valid_out, req_idx_out);
    end
    tick();
    drain_all();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      req_valid_in  = 4'($urandom_range(0, 15));
      req_ready_out = ($urandom_range(0, 3) != 0);
      flush_req     = ($urandom_range(0, 30) == 0);
      rsp_valid_in  = 1'b0;
      if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        rsp_valid_in = 1'b1;
        rsp_idx_in   = 2'(out_q[$urandom_range(0, out_q.size() - 1)]);
      end
      settle();
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      tick();
    end
    drain_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_fill();
    test_single();
    test_same_cycle();
    test_ready_low();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_credit_arbiter.md
# VX_credit_arbiter

Round-robin arbiter that shares one downstream request port among `NUM_REQS` requesters while enforcing a global outstanding-request budget (`SIZE`) and a per-requester budget (`PER_REQ`). It tracks in-flight requests by counting issues against returned responses. It also provides a flush handshake that stops new issues until all outstanding requests have drained. It sits in front of shared memory/service ports where response slots are finite and must not be oversubscribed.

## Interface
- `NUM_REQS`, 4, number of requesters (≥1)
- `SIZE`, 8, max total outstanding requests (≥1)
- `PER_REQ`, 4, max outstanding per requester (1..SIZE)
- `REQ_SELW`, `LOG2UP(NUM_REQS)`, requester index width
- `SIZEW`, `$clog2(SIZE+1)`, total counter width; `CNTW` = `$clog2(PER_REQ+1)` per-requester counter width
- `clk` in 1 clock
- `reset` in 1 asynchronous, active-high reset
- `req_valid_in` in NUM_REQS per-requester request valid
- `req_ready_in` out NUM_REQS per-requester accept (one-hot or zero)
- `req_valid_out` out 1 downstream request valid
- `req_idx_out` out REQ_SELW winning requester index
- `req_ready_out` in 1 downstream accept
- `rsp_valid_in` in 1 response returned, always consumed
- `rsp_idx_in` in REQ_SELW requester owning the response
- `flush_req` in 1 request drain
- `flush_ack` out 1 one-cycle drain-complete pulse
- `pending_size` out SIZEW total outstanding count
- `empty` out 1 pending_size == 0
- `full` out 1 pending_size == SIZE

## Operation
- Issue fire: `req_valid_out && req_ready_out`. Response event: `rsp_valid_in`.
- Eligible[i] = `req_valid_in[i] && cnt[i] != PER_REQ && !full && state==RUN`.
- Grant is combinational round-robin over Eligible, starting at `rr_ptr`. `req_valid_out` = any eligible. `req_idx_out` = winner (0 when none). `req_ready_in[i]` = `req_valid_out && winner==i && req_ready_out`.
- `req_valid_out` never depends on `req_ready_out`.
- On fire: `rr_ptr` ← winner+1, wrapping modulo NUM_REQS. Otherwise `rr_ptr` holds.
- Per-requester counters: `cnt[i]` ← `cnt[i]` + (fire && winner==i) − (rsp && rsp_idx_in==i). Issue and response on the same requester in the same cycle net zero.
- Total: `pending_size` ← `pending_size` + fire − rsp.
- `empty` and `full` are registered from the next-state value, so they are valid in the same cycle as `pending_size`.
- A response while the target `cnt` is 0, or while `empty`, is a runtime error: assert, no wrap required.
- An issue while `full` or while `cnt==PER_REQ` is impossible by construction; assert it anyway.
- FSM states:
  - RUN: `flush_req` → DRAIN.
  - DRAIN: issue blocked, responses still counted. When registered `empty`==1 → ACK.
  - ACK: `flush_ack`=1 for this cycle only, issue blocked → RUN unconditionally.
- If `flush_req` is still high after ACK, the FSM re-enters DRAIN on the next cycle.
- `flush_req` arriving while already empty: RUN → DRAIN → ACK, so ack appears 2 cycles after the request.

## Timing
- Reset (async assert, sync release) drives: `pending_size`=0, `empty`=1, `full`=0, all `cnt`=0, `rr_ptr`=0, state=RUN, `flush_ack`=0, `req_valid_out`=0.
- Reset mid-flight discards all outstanding credits. Responses arriving after reset are illegal.
- Arbitration latency: 0 cycles, with a request valid in the same cycle as `req_valid_in`.
- Counter/flag update latency: 1 cycle after the fire or response edge.
- A response in cycle t makes a blocked requester eligible in t+1. With `full` at t, issue resumes at t+1.
- `flush_req` seen at edge t: no issue from cycle t+1 onward. A fire in cycle t itself completes normally.

## Test plan
- Reset, then all 4 requesters valid with ready_out=1 and no responses, SIZE=8, PER_REQ=4 → grants 0,1,2,3,0,1,2,3, then `full`=1, `pending_size`=8, `req_valid_out`=0.
- Only requester 2 valid, PER_REQ=4 → 4 grants, then stall. A single rsp_idx=2 → one more grant on the next cycle; `pending_size` sequence 1,2,3,4,3,4.
- Simultaneous fire(idx 1) and rsp(idx 1) with cnt[1]=2 → cnt[1] stays 2, `pending_size` unchanged, `full`/`empty` unchanged.
- `req_ready_out`=0 for 3 cycles with requesters 0 and 3 valid → `req_idx_out` stays 0, `rr_ptr` stays 0, no `req_ready_in` asserted. Ready rises → requester 0 fires, then requester 3.
- 3 outstanding, pulse `flush_req` → no issues while draining. Return 3 responses → `empty`=1, then `flush_ack` pulses exactly one cycle and issuing resumes.
- Assert `reset` asynchronously mid-burst with 5 outstanding → outputs return to reset values immediately, before the next edge. After release, requester 0 wins first.
